stack_engine: RTL and testbench

//   Parametrised hardware data stack for the CPU core: owns the stack pointer,
//   the distributed-RAM storage (async read, sync write) and overflow/underflow

---
 rtl/stack_engine.sv | 123 ++++++++++++
 tb/tb_stack_engine.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_engine.sv
// stack_engine: hardware data stack with single-cycle pop(0..2)+push,
// combinational TOS/NOS/peek reads and sticky overflow/underflow flags.
module stack_engine #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned DEPTH  = 8192
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic [1:0]        pop_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              err_clr,
    input  logic [ADDR_W-1:0] pick_idx,
    output logic [DATA_W-1:0] tos,
    output logic [DATA_W-1:0] nos,
    output logic [DATA_W-1:0] pick_data,
    output logic [ADDR_W:0]   count,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              underflow
);

    // Legality math is done two bits wider than the address so sp-pop_n+1
    // can neither wrap below zero nor past DEPTH unnoticed.
    localparam int unsigned CW = ADDR_W + 2;
    localparam int unsigned SW = ADDR_W + 1;
    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [SW-1:0]     sp;
    logic [DATA_W-1:0] mem [DEPTH];

    logic [CW-1:0]     sp_x;
    logic [CW-1:0]     pop_x;
    logic [CW-1:0]     base_x;
    logic              under_c;
    logic              over_c;
    logic              legal_c;
    logic              we_c;
    logic              set_ov_c;
    logic              set_un_c;
    logic [IW-1:0]     wr_idx_c;
    logic [SW-1:0]     sp_nxt_c;

    logic [SW-1:0]     tos_addr_c;
    logic [SW-1:0]     nos_addr_c;
    logic [SW-1:0]     pick_addr_c;

    // Decode the requested op: legality, write slot and next stack pointer.
    always_comb begin
        sp_x     = CW'(sp);
        pop_x    = CW'(pop_n);
        base_x   = sp_x - pop_x;
        under_c  = (pop_n == 2'd3) || (pop_x > sp_x);
        over_c   = !under_c && push && ((base_x + CW'(1)) > CW'(DEPTH));
        legal_c  = !clear && !under_c && !over_c;
        we_c     = legal_c && push;
        set_ov_c = !clear && over_c;
        set_un_c = !clear && under_c;
        wr_idx_c = IW'(base_x);
        sp_nxt_c = sp;
        if (clear) begin
            sp_nxt_c = '0;
        end else if (legal_c) begin
            sp_nxt_c = SW'(base_x + CW'(push));
        end
    end

    // Stack pointer plus registered status derived from its next value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp    <= '0;
            empty <= 1'b1;
            full  <= 1'b0;
        end else begin
            sp    <= sp_nxt_c;
            empty <= (sp_nxt_c == '0);
            full  <= (sp_nxt_c == SW'(DEPTH));
        end
    end

    // Sticky error flags; a new error in the same cycle beats err_clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= set_ov_c || (overflow && !err_clr);
            underflow <= set_un_c || (underflow && !err_clr);
        end
    end

    // Storage write port; no write lands while reset is held.
    always_ff @(posedge clk) begin
        if (we_c && rst_n) begin
            mem[wr_idx_c] <= push_data;
        end
    end

    assign count = sp;

    // Asynchronous read ports, forced to zero when the slot is not live.
    always_comb begin
        tos_addr_c  = sp - SW'(1);
        nos_addr_c  = sp - SW'(2);
        pick_addr_c = sp - SW'(1) - SW'(pick_idx);
        tos         = '0;
        nos         = '0;
        pick_data   = '0;
        if (sp != '0) begin
            tos = mem[IW'(tos_addr_c)];
        end
        if (sp >= SW'(2)) begin
            nos = mem[IW'(nos_addr_c)];
        end
        if (SW'(pick_idx) < sp) begin
            pick_data = mem[IW'(pick_addr_c)];
        end
    end

endmodule

// File: tb/tb_stack_engine.sv
// tb_stack_engine: directed scenarios plus random traffic against a
// queue-based stack model, compared every falling edge.
module tb_stack_engine;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 4;
    localparam int          DEPTH  = 4;

    logic              clk;
    logic              rst_n;
    logic              clear;
    logic [1:0]        pop_n;
    logic              push;
    logic [DATA_W-1:0] push_data;
    logic              err_clr;
    logic [ADDR_W-1:0] pick_idx;
    logic [DATA_W-1:0] tos;
    logic [DATA_W-1:0] nos;
    logic [DATA_W-1:0] pick_data;
    logic [ADDR_W:0]   count;
    logic              empty;
    logic              full;
    logic              overflow;
    logic              underflow;

    int checks;
    int failures;

    stack_engine #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .pop_n     (pop_n),
        .push      (push),
        .push_data (push_data),
        .err_clr   (err_clr),
        .pick_idx  (pick_idx),
        .tos       (tos),
        .nos       (nos),
        .pick_data (pick_data),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the stack is a queue, back = TOS.
    logic [DATA_W-1:0] q[$];
    logic m_ov;
    logic m_un;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_ov = 1'b0;
            m_un = 1'b0;
        end else if (clear) begin
            q.delete();
            if (err_clr) begin
                m_ov = 1'b0;
                m_un = 1'b0;
            end
        end else begin
            int sz;
            int pn;
            bit un;
            bit ov;
            sz = q.size();
            pn = int'(pop_n);
            un = (pn == 3) || (pn > sz);
            ov = !un && push && (sz - pn + 1 > DEPTH);
            if (!un && !ov) begin
                repeat (pn) void'(q.pop_back());
                if (push) q.push_back(push_data);
            end
            m_un = un || (m_un && !err_clr);
            m_ov = ov || (m_ov && !err_clr);
        end
    end

    // Compare every output against the model away from the active edge.
    always @(negedge clk) begin
        int sz;
        int pi;
        logic [DATA_W-1:0] e_tos;
        logic [DATA_W-1:0] e_nos;
        logic [DATA_W-1:0] e_pick;
        sz     = q.size();
        pi     = int'(pick_idx);
        e_tos  = (sz >= 1) ? q[sz-1] : '0;
        e_nos  = (sz >= 2) ? q[sz-2] : '0;
        e_pick = (pi < sz) ? q[sz-1-pi] : '0;
        chk("m_count", 32'(count), 32'(sz));
        chk("m_empty", 32'(empty), 32'(sz == 0));
        chk("m_full", 32'(full), 32'(sz == DEPTH));
        chk("m_overflow", 32'(overflow), 32'(m_ov));
        chk("m_underflow", 32'(underflow), 32'(m_un));
        chk("m_tos", 32'(tos), 32'(e_tos));
        chk("m_nos", 32'(nos), 32'(e_nos));
        chk("m_pick", 32'(pick_data), 32'(e_pick));
    end

    task automatic drive(input logic c, input logic [1:0] p, input logic ps,
                         input logic [DATA_W-1:0] d, input logic ec);
        clear     = c;
        pop_n     = p;
        push      = ps;
        push_data = d;
        err_clr   = ec;
        @(posedge clk);
        #1;
        clear   = 1'b0;
        pop_n   = 2'd0;
        push    = 1'b0;
        err_clr = 1'b0;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        clear     = 1'b0;
        pop_n     = 2'd0;
        push      = 1'b0;
        push_data = '0;
        err_clr   = 1'b0;
        pick_idx  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_tos", 32'(tos), 32'd0);

        // Three pushes, then peeks
        drive(1'b0, 2'd0, 1'b1, 16'h1111, 1'b0);
        drive(1'b0, 2'd0, 1'b1, 16'h2222, 1'b0);
        drive(1'b0, 2'd0, 1'b1, 16'h3333, 1'b0);
        chk("t1_count", 32'(count), 32'd3);
        chk("t1_tos", 32'(tos), 32'h3333);
        chk("t1_nos", 32'(nos), 32'h2222);
        pick_idx = 4'd2;
        #1;
        chk("t1_pick2", 32'(pick_data), 32'h1111);
        pick_idx = 4'd3;
        #1;
        chk("t1_pick3", 32'(pick_data), 32'h0);

        // ALU-style pop two push one
        drive(1'b0, 2'd2, 1'b1, 16'hABCD, 1'b0);
        chk("t2_count", 32'(count), 32'd2);
        chk("t2_tos", 32'(tos), 32'hABCD);
        chk("t2_nos", 32'(nos), 32'h1111);

        // Underflow cases
        drive(1'b0, 2'd1, 1'b0, 16'h0, 1'b0);
        drive(1'b0, 2'd2, 1'b0, 16'h0, 1'b0);
        chk("t3_under", 32'(underflow), 32'd1);
        chk("t3_count", 32'(count), 32'd1);
        chk("t3_tos", 32'(tos), 32'h1111);
        drive(1'b0, 2'd0, 1'b0, 16'h0, 1'b1);
        chk("t3_errclr", 32'(underflow), 32'd0);
        drive(1'b0, 2'd3, 1'b1, 16'h5555, 1'b0);
        chk("t3_pop3_under", 32'(underflow), 32'd1);
        chk("t3_pop3_count", 32'(count), 32'd1);
        chk("t3_pop3_tos", 32'(tos), 32'h1111);
        drive(1'b0, 2'd3, 1'b0, 16'h0, 1'b1);
        chk("t3_set_wins", 32'(underflow), 32'd1);
        drive(1'b0, 2'd0, 1'b0, 16'h0, 1'b1);

        // Fill to DEPTH, overflow, in-place replace at full
        drive(1'b0, 2'd0, 1'b1, 16'h0002, 1'b0);
        drive(1'b0, 2'd0, 1'b1, 16'h0003, 1'b0);
        drive(1'b0, 2'd0, 1'b1, 16'h0004, 1'b0);
        chk("t4_full", 32'(full), 32'd1);
        drive(1'b0, 2'd0, 1'b1, 16'h0005, 1'b0);
        chk("t4_over", 32'(overflow), 32'd1);
        chk("t4_count", 32'(count), 32'd4);
        chk("t4_tos_kept", 32'(tos), 32'h0004);
        drive(1'b0, 2'd1, 1'b1, 16'hBEEF, 1'b0);
        chk("t4_replace", 32'(tos), 32'hBEEF);
        chk("t4_over_sticky", 32'(overflow), 32'd1);
        chk("t4_full_after", 32'(count), 32'd4);
        drive(1'b0, 2'd0, 1'b0, 16'h0, 1'b1);

        // Clear beats push in the same cycle
        drive(1'b0, 2'd1, 1'b0, 16'h0, 1'b0);
        drive(1'b1, 2'd0, 1'b1, 16'h7777, 1'b0);
        chk("t5_count", 32'(count), 32'd0);
        chk("t5_empty", 32'(empty), 32'd1);
        chk("t5_tos", 32'(tos), 32'h0);
        chk("t5_noflag", 32'({overflow, underflow}), 32'd0);

        // Empty-stack edge cases
        drive(1'b0, 2'd1, 1'b1, 16'h1234, 1'b0);
        chk("e_pop1push_under", 32'(underflow), 32'd1);
        chk("e_pop1push_count", 32'(count), 32'd0);
        drive(1'b0, 2'd0, 1'b1, 16'h4321, 1'b1);
        chk("e_push_count", 32'(count), 32'd1);
        chk("e_push_tos", 32'(tos), 32'h4321);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [1:0] p;
            p = 2'($urandom_range(0, 15) == 0 ? 3 : $urandom_range(0, 2));
            pick_idx = 4'($urandom_range(0, 15));
            drive(1'($urandom_range(0, 31) == 0), p, 1'($urandom_range(0, 1)),
                  16'($urandom), 1'($urandom_range(0, 7) == 0));
        end

        // Asynchronous reset between edges
        drive(1'b0, 2'd3, 1'b0, 16'h0, 1'b0);
        drive(1'b0, 2'd0, 1'b1, 16'h9999, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_count", 32'(count), 32'd0);
        chk("t6_flags", 32'({overflow, underflow}), 32'd0);
        chk("t6_empty", 32'(empty), 32'd1);
        chk("t6_tos", 32'(tos), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
